zero_cross_tracker: RTL and testbench
=====================================

Name: zero_cross_tracker

Overview:
Parametrised, continuously tracking zero-cross detector for periodic sampled signals. It learns the mid level, (max+min)/2, over one period of N samples. It then finds the sample index nearest that level on the selected slope and emits a one-clock pulse at that index every period. It keeps re-measuring every period so it follows amplitude, offset and phase drift, and drops lock when the signal disappears. It sits between the ADC sample stream and the phase/lock-in blocks that need a per-period reference strobe.

Parameters:
DATA_W, 14, sample width.
CNT_W, 16, width of period length and position counters.
SIGNED_IN, 0, 1 means data is two's complement; 0 means unsigned.
MIN_AMP, 16, minimum (max-min) for a period to be usable.
LOSS_PERIODS, 2, consecutive unusable periods in TRACK before lock is dropped.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  when low, samples are ignored and all state freezes
restart  in  1  synchronous; forces IDLE, clears lock
ptos_x_ciclo  in  CNT_W  samples per period N
edge_sel  in  1  0 selects the rising-slope crossing, 1 selects falling
data  in  DATA_W  sample
data_valid  in  1  sample qualifier
zero_cross  out  1  one-clock crossing pulse
locked  out  1  high while in TRACK
cross_index  out  CNT_W  current crossing position within the period
mid_level  out  DATA_W  last latched mid level
amplitude  out  DATA_W  last latched max-min, unsigned
amp_err  out  1  one-clock pulse at a period boundary whose amplitude < MIN_AMP

Behaviour:
- Reset/restart values: all outputs 0, state IDLE, pos 0. Running max initialises to the most negative representable value, running min to the most positive (respecting SIGNED_IN). best_diff initialises to all ones. miss_cnt is 0. restart has priority over sample processing in the same cycle; reset_n overrides everything.
- A sample is accepted only when enable && data_valid. All counters, registers and the FSM advance only on accepted samples, with two exceptions: the IDLE exit check, and restart.
- pos counts accepted samples 0..N-1 and then wraps. A boundary is an accepted sample with pos==N-1.
- N is latched on the IDLE->ACQ transition. Later changes to ptos_x_ciclo are ignored until restart.
- prev holds the last accepted sample and is updated in every state except IDLE.
- Slope match:
  - edge_sel=0: data > prev.
  - edge_sel=1: data < prev.
  - Equal samples never match.
  - The first accepted sample after IDLE never matches.
- Arithmetic:
  - Comparisons are signed or unsigned per SIGNED_IN.
  - mid = min + ((max-min)>>1), with the difference computed in DATA_W+1 bits, so there is no overflow.
  - diff = |data - mid| in DATA_W+1 bits, unsigned.
  - A candidate is a sample with slope match and diff < best_diff (strict, so the earliest position wins ties). A candidate records best_pos=pos.
- IDLE: on enable=1 with N>=2, go to ACQ. N<2 stays in IDLE.
- ACQ: accumulate running max/min over one period. At the boundary:
  - Latch mid_level and amplitude.
  - Reset the running max/min.
  - Go to SEARCH.
- SEARCH: search for candidates against the latched mid while also accumulating new max/min. At the boundary:
  - Latch the new mid and amplitude.
  - If a candidate was found and the amplitude used for the search is >= MIN_AMP: cross_index<=best_pos, locked<=1, go to TRACK.
  - Otherwise stay in SEARCH; if the amplitude was the failing condition, pulse amp_err.
  - In both cases, reset best_diff.
- TRACK: same per-period search and accumulation as SEARCH. At each boundary:
  - A usable period updates cross_index and clears miss_cnt.
  - An unusable period keeps cross_index and increments miss_cnt.
  - When miss_cnt reaches LOSS_PERIODS: locked<=0, go to ACQ.
- zero_cross: registered; high for exactly one clk on the cycle after an accepted sample with state==TRACK and pos==cross_index. A boundary sample compares against the pre-update cross_index.
- enable low mid-period: the period resumes where it stopped, and zero_cross is 0.

Test Plan:
- Rising lock:
  - Stimulus: DATA_W=14 unsigned, N=16, data=8192+round(4000*sin(2πk/16)) on every clk, edge_sel=0.
  - Response: after sample 15, mid_level=8192 and amplitude=8000. After sample 31, locked=1 and cross_index=0. zero_cross pulses the clk after samples 32, 48, 64, ...
- Falling edge: same stimulus with edge_sel=1 -> cross_index=8; pulses after samples 40, 56, ...
- Phase shift:
  - Stimulus: once locked, delay the sine by 3 samples.
  - Response: within 2 boundaries cross_index=3 and locked stays 1.
- Loss of signal:
  - Stimulus: once locked, hold data=8192.
  - Response: amp_err pulses at each boundary. locked falls at the 2nd boundary and the state returns to ACQ. No zero_cross pulses after the loss.
- Signed mode: SIGNED_IN=1, data=round(4000*sin(2πk/16)) -> mid_level=0 and cross_index=0.
- Gaps and reset:
  - Toggle data_valid 50% -> same cross_index and pulse count per period as the rising-lock case.
  - Assert reset_n low mid-TRACK -> all outputs read 0 in the same cycle; relock takes 32 accepted samples.

Source files
------------

// File: rtl/zero_cross_tracker.sv
// Continuously tracking zero-cross detector: learns (max+min)/2 over each period of N
// samples and strobes once per period at the sample index nearest that level on one slope.
module zero_cross_tracker #(
   parameter int unsigned DATA_W       = 14,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned SIGNED_IN    = 0,
   parameter int unsigned MIN_AMP      = 16,
   parameter int unsigned LOSS_PERIODS = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              restart,
   input  logic [CNT_W-1:0]  ptos_x_ciclo,
   input  logic              edge_sel,
   input  logic [DATA_W-1:0] data,
   input  logic              data_valid,
   output logic              zero_cross,
   output logic              locked,
   output logic [CNT_W-1:0]  cross_index,
   output logic [DATA_W-1:0] mid_level,
   output logic [DATA_W-1:0] amplitude,
   output logic              amp_err
);

   localparam int unsigned EW     = DATA_W + 1;
   localparam int unsigned MISS_W = (LOSS_PERIODS < 2) ? 1 : $clog2(LOSS_PERIODS + 1);

   localparam logic [DATA_W-1:0] MAX_INIT = (SIGNED_IN != 0) ?
      {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] MIN_INIT = (SIGNED_IN != 0) ?
      {1'b0, {(DATA_W-1){1'b1}}} : {DATA_W{1'b1}};
   localparam logic [EW-1:0]     MIN_AMP_V = EW'(MIN_AMP);
   localparam logic [MISS_W-1:0] LOSS_V    = MISS_W'(LOSS_PERIODS);

   typedef enum logic [1:0] {StIdle, StAcq, StSearch, StTrack} state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    n_q;
   logic [CNT_W-1:0]    pos_q;
   logic [CNT_W-1:0]    best_pos_q;
   logic [DATA_W-1:0]   prev_q;
   logic                prev_vld_q;
   logic [DATA_W-1:0]   max_q;
   logic [DATA_W-1:0]   min_q;
   logic [EW-1:0]       best_diff_q;
   logic [MISS_W-1:0]   miss_q;

   // Sign- or zero-extend by one bit so every compare can be done as signed.
   function automatic logic signed [EW-1:0] ext(input logic [DATA_W-1:0] v);
      return (SIGNED_IN != 0) ? $signed({v[DATA_W-1], v}) : $signed({1'b0, v});
   endfunction

   logic                 accept;
   logic                 boundary;
   logic                 searching;
   logic signed [EW-1:0] data_e;
   logic signed [EW-1:0] prev_e;
   logic signed [EW-1:0] mid_e;
   logic signed [EW-1:0] max_nxt_e;
   logic signed [EW-1:0] min_nxt_e;
   logic signed [EW-1:0] delta;
   logic [DATA_W-1:0]    max_nxt;
   logic [DATA_W-1:0]    min_nxt;
   logic [DATA_W-1:0]    mid_nxt;
   logic [EW-1:0]        span;
   logic [EW-1:0]        diff;
   logic                 slope;
   logic                 cand;
   logic                 found;
   logic                 amp_ok;
   logic                 usable;
   logic [CNT_W-1:0]     best_pos_nxt;
   logic [MISS_W-1:0]    miss_inc;

   assign accept    = enable & data_valid;
   assign boundary  = accept & (pos_q == n_q - CNT_W'(1));
   assign searching = (state_q == StSearch) || (state_q == StTrack);

   assign data_e = ext(data);
   assign prev_e = ext(prev_q);
   assign mid_e  = ext(mid_level);

   assign max_nxt   = (data_e > ext(max_q)) ? data : max_q;
   assign min_nxt   = (data_e < ext(min_q)) ? data : min_q;
   assign max_nxt_e = ext(max_nxt);
   assign min_nxt_e = ext(min_nxt);
   assign span      = max_nxt_e - min_nxt_e;
   assign mid_nxt   = DATA_W'(min_nxt_e + (span >> 1));

   assign delta = data_e - mid_e;
   assign diff  = delta[EW-1] ? -delta : delta;

   assign slope  = prev_vld_q & (edge_sel ? (data_e < prev_e) : (data_e > prev_e));
   assign cand   = searching & slope & (diff < best_diff_q);
   // best_diff_q only leaves all-ones once a candidate has been recorded this period.
   assign found  = cand | (best_diff_q != {EW{1'b1}});
   assign amp_ok = {1'b0, amplitude} >= MIN_AMP_V;
   assign usable = found & amp_ok;

   assign best_pos_nxt = cand ? pos_q : best_pos_q;
   assign miss_inc     = miss_q + MISS_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         n_q         <= '0;
         pos_q       <= '0;
         best_pos_q  <= '0;
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         max_q       <= MAX_INIT;
         min_q       <= MIN_INIT;
         best_diff_q <= '1;
         miss_q      <= '0;
         zero_cross  <= 1'b0;
         locked      <= 1'b0;
         cross_index <= '0;
         mid_level   <= '0;
         amplitude   <= '0;
         amp_err     <= 1'b0;
      end else if (restart) begin
         state_q     <= StIdle;
         n_q         <= '0;
         pos_q       <= '0;
         best_pos_q  <= '0;
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         max_q       <= MAX_INIT;
         min_q       <= MIN_INIT;
         best_diff_q <= '1;
         miss_q      <= '0;
         zero_cross  <= 1'b0;
         locked      <= 1'b0;
         cross_index <= '0;
         mid_level   <= '0;
         amplitude   <= '0;
         amp_err     <= 1'b0;
      end else begin
         zero_cross <= 1'b0;
         amp_err    <= 1'b0;
         if (state_q == StIdle) begin
            if (enable && (ptos_x_ciclo >= CNT_W'(2))) begin
               n_q     <= ptos_x_ciclo;
               pos_q   <= '0;
               state_q <= StAcq;
            end
         end else if (accept) begin
            zero_cross <= (state_q == StTrack) && (pos_q == cross_index);
            prev_q     <= data;
            prev_vld_q <= 1'b1;
            pos_q      <= boundary ? '0 : pos_q + CNT_W'(1);

            if (boundary) begin
               mid_level <= mid_nxt;
               amplitude <= DATA_W'(span);
               max_q     <= MAX_INIT;
               min_q     <= MIN_INIT;
            end else begin
               max_q <= max_nxt;
               min_q <= min_nxt;
            end

            if (searching) begin
               if (boundary) begin
                  best_diff_q <= '1;
                  amp_err     <= ~amp_ok;
                  if (usable) begin
                     cross_index <= best_pos_nxt;
                     locked      <= 1'b1;
                     miss_q      <= '0;
                     state_q     <= StTrack;
                  end else if (state_q == StTrack) begin
                     if (miss_inc == LOSS_V) begin
                        locked  <= 1'b0;
                        miss_q  <= '0;
                        state_q <= StAcq;
                     end else begin
                        miss_q <= miss_inc;
                     end
                  end
               end else if (cand) begin
                  best_diff_q <= diff;
                  best_pos_q  <= pos_q;
               end
            end else if (boundary) begin
               state_q <= StSearch;
            end
         end
      end
   end

endmodule

// File: tb/tb_zero_cross_tracker.sv
// Bench for zero_cross_tracker: scoreboard of per-sample zero_cross/amp_err expectations
// plus inline checks of lock, crossing index and latched levels.
module tb_zero_cross_tracker;

   localparam int DW = 14;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset_n, enable, restart, edge_sel, data_valid;
   logic [CW-1:0] ptos;
   logic [DW-1:0] data;
   logic          zero_cross, locked, amp_err;
   logic [CW-1:0] cross_index;
   logic [DW-1:0] mid_level, amplitude;

   logic          enable_s, valid_s;
   logic [DW-1:0] data_s;
   logic          zero_cross_s, locked_s, amp_err_s;
   logic [CW-1:0] cross_index_s;
   logic [DW-1:0] mid_level_s, amplitude_s;

   typedef struct packed {
      logic zc;
      logic ae;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   zero_cross_tracker #(.DATA_W(DW), .CNT_W(CW), .SIGNED_IN(0), .MIN_AMP(16),
                        .LOSS_PERIODS(2)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
      .ptos_x_ciclo(ptos), .edge_sel(edge_sel), .data(data), .data_valid(data_valid),
      .zero_cross(zero_cross), .locked(locked), .cross_index(cross_index),
      .mid_level(mid_level), .amplitude(amplitude), .amp_err(amp_err)
   );

   zero_cross_tracker #(.DATA_W(DW), .CNT_W(CW), .SIGNED_IN(1), .MIN_AMP(16),
                        .LOSS_PERIODS(2)) dut_s (
      .clk(clk), .reset_n(reset_n), .enable(enable_s), .restart(restart),
      .ptos_x_ciclo(ptos), .edge_sel(edge_sel), .data(data_s), .data_valid(valid_s),
      .zero_cross(zero_cross_s), .locked(locked_s), .cross_index(cross_index_s),
      .mid_level(mid_level_s), .amplitude(amplitude_s), .amp_err(amp_err_s)
   );

   // round(4000*sin(2*pi*k/16))
   function automatic int sine(input int k);
      int m;
      m = ((k % 16) + 16) % 16;
      case (m)
         0, 8:    return 0;
         1, 7:    return 1531;
         2, 6:    return 2828;
         3, 5:    return 3696;
         4:       return 4000;
         9, 15:   return -1531;
         10, 14:  return -2828;
         11, 13:  return -3696;
         default: return -4000;
      endcase
   endfunction

   function automatic logic [DW-1:0] u(input int k);
      return DW'(8192 + sine(k));
   endfunction

   // One clock of stimulus; the expectation for the registered outputs is queued now and
   // retired once the edge that produces them has passed.
   task automatic step(input logic [DW-1:0] d, input logic v, input logic en,
                       input logic ezc, input logic eae);
      exp_t e;
      data = d;
      data_valid = v;
      enable = en;
      e.zc = ezc;
      e.ae = eae;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (zero_cross !== e.zc) begin
         bad++;
         $display("FAIL zero_cross t=%0t got=%b want=%b", $time, zero_cross, e.zc);
      end
      total++;
      if (amp_err !== e.ae) begin
         bad++;
         $display("FAIL amp_err t=%0t got=%b want=%b", $time, amp_err, e.ae);
      end
   endtask

   task automatic start_run(input logic es, input logic [CW-1:0] n);
      restart = 1'b1;
      edge_sel = es;
      ptos = n;
      enable = 1'b1;
      data_valid = 1'b0;
      @(posedge clk);
      #1;
      restart = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      restart = 1'b0;
      enable = 1'b0;
      data_valid = 1'b0;
      edge_sel = 1'b0;
      data = '0;
      ptos = 16;
      enable_s = 1'b0;
      valid_s = 1'b0;
      data_s = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (zero_cross !== 1'b0) begin bad++;
         $display("FAIL reset_zero_cross got=%b want=0", zero_cross); end
      total++; if (locked !== 1'b0) begin bad++;
         $display("FAIL reset_locked got=%b want=0", locked); end
      total++; if (cross_index !== '0) begin bad++;
         $display("FAIL reset_cross_index got=%0d want=0", cross_index); end
      total++; if (mid_level !== '0) begin bad++;
         $display("FAIL reset_mid_level got=%0d want=0", mid_level); end
      total++; if (amplitude !== '0) begin bad++;
         $display("FAIL reset_amplitude got=%0d want=0", amplitude); end
      total++; if (amp_err !== 1'b0) begin bad++;
         $display("FAIL reset_amp_err got=%b want=0", amp_err); end
      reset_n = 1'b1;
   endtask

   task automatic test_short_period();
      start_run(1'b0, 1);
      for (int s = 0; s < 40; s++) step(u(s), 1'b1, 1'b1, 1'b0, 1'b0);
      total++; if (locked !== 1'b0) begin bad++;
         $display("FAIL short_period_locked got=%b want=0", locked); end
      total++; if (mid_level !== '0) begin bad++;
         $display("FAIL short_period_mid got=%0d want=0", mid_level); end
   endtask

   task automatic test_rising_lock();
      start_run(1'b0, 16);
      ptos = 7;  // must be ignored once latched
      for (int s = 0; s < 80; s++) begin
         step(u(s), 1'b1, 1'b1, (s >= 32) && (s % 16 == 0), 1'b0);
         if (s == 15) begin
            total++; if (mid_level !== 14'd8192) begin bad++;
               $display("FAIL rising_mid got=%0d want=8192", mid_level); end
            total++; if (amplitude !== 14'd8000) begin bad++;
               $display("FAIL rising_amp got=%0d want=8000", amplitude); end
            total++; if (locked !== 1'b0) begin bad++;
               $display("FAIL rising_early_lock got=%b want=0", locked); end
         end
         if (s == 31) begin
            total++; if (locked !== 1'b1) begin bad++;
               $display("FAIL rising_locked got=%b want=1", locked); end
            total++; if (cross_index !== 16'd0) begin bad++;
               $display("FAIL rising_cross got=%0d want=0", cross_index); end
         end
      end
   endtask

   task automatic test_falling();
      start_run(1'b1, 16);
      for (int s = 0; s < 64; s++) begin
         step(u(s), 1'b1, 1'b1, (s >= 40) && ((s - 40) % 16 == 0), 1'b0);
         if (s == 31) begin
            total++; if (locked !== 1'b1) begin bad++;
               $display("FAIL falling_locked got=%b want=1", locked); end
            total++; if (cross_index !== 16'd8) begin bad++;
               $display("FAIL falling_cross got=%0d want=8", cross_index); end
         end
      end
   endtask

   task automatic test_phase_shift();
      start_run(1'b0, 16);
      for (int s = 0; s < 96; s++) begin
         step((s < 48) ? u(s) : u(s - 3), 1'b1, 1'b1,
              (s == 32) || (s == 48) || ((s >= 67) && ((s - 67) % 16 == 0)), 1'b0);
         if (s == 63 || s == 79) begin
            total++; if (cross_index !== 16'd3) begin bad++;
               $display("FAIL phase_cross s=%0d got=%0d want=3", s, cross_index); end
            total++; if (locked !== 1'b1) begin bad++;
               $display("FAIL phase_locked s=%0d got=%b want=1", s, locked); end
         end
      end
   endtask

   task automatic test_loss();
      start_run(1'b0, 16);
      for (int s = 0; s < 131; s++) begin
         step((s >= 48 && s < 96) ? 14'd8192 : u(s), 1'b1, 1'b1,
              (s == 32) || (s == 48) || (s == 64) || (s == 80) || (s == 128),
              (s == 79) || (s == 95));
         if (s == 94) begin
            total++; if (locked !== 1'b1) begin bad++;
               $display("FAIL loss_still_locked got=%b want=1", locked); end
         end
         if (s == 95 || s == 126) begin
            total++; if (locked !== 1'b0) begin bad++;
               $display("FAIL loss_unlocked s=%0d got=%b want=0", s, locked); end
         end
         if (s == 127) begin
            total++; if (locked !== 1'b1) begin bad++;
               $display("FAIL loss_relock got=%b want=1", locked); end
            total++; if (cross_index !== 16'd0) begin bad++;
               $display("FAIL loss_relock_cross got=%0d want=0", cross_index); end
         end
      end
   endtask

   task automatic test_gaps();
      int a;
      int c;
      a = 0;
      c = 0;
      start_run(1'b0, 16);
      while (a < 80 && c < 1000) begin
         case (c % 4)
            0, 2: begin
               step(u(a), 1'b1, 1'b1, (a >= 32) && (a % 16 == 0), 1'b0);
               if (a == 31) begin
                  total++; if (cross_index !== 16'd0 || locked !== 1'b1) begin bad++;
                     $display("FAIL gaps_lock got=%0d/%b want=0/1", cross_index, locked);
                  end
               end
               a++;
            end
            1:       step(DW'($urandom_range(0, 16383)), 1'b0, 1'b1, 1'b0, 1'b0);
            default: step(DW'($urandom_range(0, 16383)), 1'b1, 1'b0, 1'b0, 1'b0);
         endcase
         c++;
      end
   endtask

   task automatic test_reset_mid_track();
      start_run(1'b0, 16);
      for (int s = 0; s < 33; s++) step(u(s), 1'b1, 1'b1, (s == 32), 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (zero_cross !== 1'b0) begin bad++;
         $display("FAIL midreset_zero_cross got=%b want=0", zero_cross); end
      total++; if (locked !== 1'b0) begin bad++;
         $display("FAIL midreset_locked got=%b want=0", locked); end
      total++; if (mid_level !== '0 || amplitude !== '0) begin bad++;
         $display("FAIL midreset_levels got=%0d/%0d want=0/0", mid_level, amplitude); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      data_valid = 1'b0;
      enable = 1'b1;
      @(posedge clk);
      #1;
      for (int s = 0; s < 33; s++) begin
         step(u(s), 1'b1, 1'b1, (s == 32), 1'b0);
         if (s == 30 || s == 31) begin
            total++; if (locked !== (s == 31)) begin bad++;
               $display("FAIL midreset_relock s=%0d got=%b want=%b", s, locked, s == 31); end
         end
      end
   endtask

   task automatic test_signed();
      enable = 1'b0;
      data_valid = 1'b0;
      edge_sel = 1'b0;
      enable_s = 1'b1;
      valid_s = 1'b0;
      @(posedge clk);
      #1;
      for (int s = 0; s < 48; s++) begin
         data_s = DW'(sine(s));
         valid_s = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if (zero_cross_s !== ((s >= 32) && (s % 16 == 0))) begin bad++;
            $display("FAIL signed_zero_cross s=%0d got=%b", s, zero_cross_s); end
         if (s == 15) begin
            total++; if (mid_level_s !== '0) begin bad++;
               $display("FAIL signed_mid got=%0d want=0", mid_level_s); end
            total++; if (amplitude_s !== 14'd8000) begin bad++;
               $display("FAIL signed_amp got=%0d want=8000", amplitude_s); end
         end
         if (s == 31) begin
            total++; if (locked_s !== 1'b1 || cross_index_s !== 16'd0) begin bad++;
               $display("FAIL signed_lock got=%b/%0d want=1/0", locked_s, cross_index_s);
            end
         end
      end
      valid_s = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_short_period();
      test_rising_lock();
      test_falling();
      test_phase_shift();
      test_loss();
      test_gaps();
      test_reset_mid_track();
      test_signed();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
